// File: rtl/mem_arb.sv
// Two-port (CPU / DMA) arbiter onto a single shared memory port with fixed
// access latency and a starvation guard that eventually forces a DMA grant.
module mem_arb #(
   parameter int AW     = 8,
   parameter int DW     = 32,
   parameter int LAT    = 2,
   parameter int STARVE = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          c_req,
   input  logic          c_we,
   input  logic [AW-1:0] c_addr,
   input  logic [DW-1:0] c_wdata,
   output logic [DW-1:0] c_rdata,
   output logic          c_done,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic [DW-1:0] d_rdata,
   output logic          d_done,
   output logic          m_en,
   output logic          m_we,
   output logic [AW-1:0] m_addr,
   output logic [DW-1:0] m_wdata,
   input  logic [DW-1:0] m_rdata,
   output logic          busy,
   output logic          owner
);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

   localparam logic [2:0] CNT_INIT   = 3'(LAT - 1);
   localparam logic [3:0] STARVE_MAX = 4'(STARVE);

   state_t        r_state;
   state_t        w_next;
   logic [2:0]    r_cnt;
   logic [3:0]    r_starve;
   logic          r_owner;
   logic          r_we;
   logic [AW-1:0] r_addr;
   logic [DW-1:0] r_wdata;
   logic [DW-1:0] r_c_rdata;
   logic [DW-1:0] r_d_rdata;

   logic          w_grant;
   logic          w_pick_d;

   assign w_grant  = c_req | d_req;
   // DMA wins outright when alone, or when the CPU has starved it long enough.
   assign w_pick_d = d_req & (~c_req | (r_starve == STARVE_MAX));

   assign c_rdata = r_c_rdata;
   assign d_rdata = r_d_rdata;
   assign owner   = r_owner;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of process ordering.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_next;
   end

   // NOTE: every output of this block gets a default first, so no path
   // through the case statement can infer a latch.
   always_comb begin
      w_next  = r_state;
      m_en    = 1'b0;
      m_we    = 1'b0;
      m_addr  = '0;
      m_wdata = '0;
      c_done  = 1'b0;
      d_done  = 1'b0;
      busy    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_grant) w_next = S_ACCESS;
         end
         S_ACCESS: begin
            busy    = 1'b1;
            m_en    = 1'b1;
            m_we    = r_we;
            m_addr  = r_addr;
            m_wdata = r_wdata;
            if (r_cnt == 3'd0) w_next = S_RESP;
         end
         S_RESP: begin
            busy   = 1'b1;
            c_done = ~r_owner;
            d_done = r_owner;
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt     <= '0;
         r_starve  <= '0;
         r_owner   <= 1'b0;
         r_we      <= 1'b0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_c_rdata <= '0;
         r_d_rdata <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_grant) begin
                  r_owner <= w_pick_d;
                  r_we    <= w_pick_d ? d_we    : c_we;
                  r_addr  <= w_pick_d ? d_addr  : c_addr;
                  r_wdata <= w_pick_d ? d_wdata : c_wdata;
                  r_cnt   <= CNT_INIT;
                  if (w_pick_d || !d_req)
                     r_starve <= '0;
                  else if (r_starve != STARVE_MAX)
                     r_starve <= r_starve + 4'd1;
               end
            end
            S_ACCESS: begin
               if (r_cnt != 3'd0) begin
                  r_cnt <= r_cnt - 3'd1;
               end else if (!r_we) begin
                  if (r_owner) r_d_rdata <= m_rdata;
                  else         r_c_rdata <= m_rdata;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb at LAT=2, STARVE=4; inputs driven and outputs
// sampled 1 time unit after each rising edge.
module tb_mem_arb;

   localparam int AW = 8;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          c_req = 1'b0, c_we = 1'b0;
   logic [AW-1:0] c_addr = '0;
   logic [DW-1:0] c_wdata = '0;
   logic [DW-1:0] c_rdata;
   logic          c_done;
   logic          d_req = 1'b0, d_we = 1'b0;
   logic [AW-1:0] d_addr = '0;
   logic [DW-1:0] d_wdata = '0;
   logic [DW-1:0] d_rdata;
   logic          d_done;
   logic          m_en, m_we;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata;
   logic [DW-1:0] m_rdata = '0;
   logic          busy, owner;

   int n_checks = 0;
   int n_pass   = 0;

   mem_arb #(.AW(AW), .DW(DW), .LAT(2), .STARVE(4)) dut (
      .clk(clk), .rst(rst),
      .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
      .c_rdata(c_rdata), .c_done(c_done),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_done(d_done),
      .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_rdata(m_rdata), .busy(busy), .owner(owner)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (busy && n < 20) begin
         tick();
         n++;
      end
      check(tag, 32'(busy), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [9:0] order;
      order = 10'b10000_10000;   // bit k = expected owner of grant k (C=0, D=1)

      // ---- reset state
      tick();
      check("rst_busy",   32'(busy),   32'd0);
      check("rst_m_en",   32'(m_en),   32'd0);
      check("rst_owner",  32'(owner),  32'd0);
      check("rst_c_rdat", c_rdata,     32'd0);
      check("rst_d_rdat", d_rdata,     32'd0);
      check("rst_done",   {30'd0, c_done, d_done}, 32'd0);
      rst = 1'b1;
      tick();
      check("idle_busy", 32'(busy), 32'd0);

      // ---- CPU read, addr 0x10
      c_req = 1'b1; c_we = 1'b0; c_addr = 8'h10; m_rdata = 32'hDEADBEEF;
      tick();                                   // cycle 1
      c_req = 1'b0;
      check("rd_c1_m_en",  32'(m_en),   32'd1);
      check("rd_c1_m_we",  32'(m_we),   32'd0);
      check("rd_c1_addr",  32'(m_addr), 32'h10);
      check("rd_c1_owner", 32'(owner),  32'd0);
      check("rd_c1_busy",  32'(busy),   32'd1);
      check("rd_c1_done",  32'(c_done), 32'd0);
      tick();                                   // cycle 2
      check("rd_c2_m_en",  32'(m_en),   32'd1);
      tick();                                   // cycle 3
      check("rd_c3_c_done", 32'(c_done), 32'd1);
      check("rd_c3_d_done", 32'(d_done), 32'd0);
      check("rd_c3_m_en",   32'(m_en),   32'd0);
      check("rd_c3_m_addr", 32'(m_addr), 32'd0);
      check("rd_c3_busy",   32'(busy),   32'd1);
      check("rd_c3_rdata",  c_rdata,     32'hDEADBEEF);
      tick();                                   // cycle 4
      check("rd_c4_c_done", 32'(c_done), 32'd0);
      check("rd_c4_busy",   32'(busy),   32'd0);
      check("rd_c4_d_rdat", d_rdata,     32'd0);

      // ---- simultaneous requests: CPU first, DMA at cycle 4
      c_req = 1'b1; c_addr = 8'h01; d_req = 1'b1; d_we = 1'b0; d_addr = 8'h02;
      m_rdata = 32'h1111_2222;
      tick();                                   // cycle 1
      c_req = 1'b0;
      check("arb_c1_owner", 32'(owner),  32'd0);
      check("arb_c1_addr",  32'(m_addr), 32'h01);
      tick(); tick();                           // cycle 3
      check("arb_c3_c_done", 32'(c_done), 32'd1);
      m_rdata = 32'hA5A5_0001;
      tick();                                   // cycle 4
      check("arb_c4_busy",  32'(busy),  32'd0);
      check("arb_c4_owner", 32'(owner), 32'd0);
      tick();                                   // cycle 5
      d_req = 1'b0;
      check("arb_c5_owner", 32'(owner),  32'd1);
      check("arb_c5_addr",  32'(m_addr), 32'h02);
      check("arb_c5_m_en",  32'(m_en),   32'd1);
      tick();                                   // cycle 6
      check("arb_c6_d_done", 32'(d_done), 32'd0);
      tick();                                   // cycle 7
      check("arb_c7_d_done", 32'(d_done), 32'd1);
      check("arb_c7_c_done", 32'(c_done), 32'd0);
      check("arb_c7_d_rdat", d_rdata,     32'hA5A5_0001);
      check("arb_c7_c_rdat", c_rdata,     32'h1111_2222);
      tick();
      check("arb_c8_d_done", 32'(d_done), 32'd0);

      // ---- starvation: both held high, expect C,C,C,C,D,C,C,C,C,D
      m_rdata = 32'h0BAD_F00D;
      c_req = 1'b1; d_req = 1'b1;
      tick();
      for (int k = 0; k < 10; k++) begin
         check($sformatf("starve_g%0d", k), 32'(owner), 32'(order[k]));
         if (k < 9) repeat (4) tick();
      end
      c_req = 1'b0; d_req = 1'b0;
      wait_idle("starve_drain");

      // ---- DMA write 0x3F <- 0x12345678
      m_rdata = 32'hFFFF_0000;
      d_req = 1'b1; d_we = 1'b1; d_addr = 8'h3F; d_wdata = 32'h12345678;
      tick();                                   // cycle 1
      d_req = 1'b0;
      for (int c = 1; c <= 2; c++) begin
         check($sformatf("wr_c%0d_m_we", c),   32'(m_we),   32'd1);
         check($sformatf("wr_c%0d_m_addr", c), 32'(m_addr), 32'h3F);
         check($sformatf("wr_c%0d_m_wdat", c), m_wdata,     32'h12345678);
         tick();
      end
      check("wr_c3_d_done", 32'(d_done), 32'd1);
      check("wr_c3_c_done", 32'(c_done), 32'd0);
      check("wr_c3_m_we",   32'(m_we),   32'd0);
      check("wr_c3_m_wdat", m_wdata,     32'd0);
      tick();
      check("wr_c4_d_done", 32'(d_done), 32'd0);
      check("wr_c_rdata",   c_rdata,     32'h0BAD_F00D);
      check("wr_d_rdata",   d_rdata,     32'h0BAD_F00D);
      d_we = 1'b0;

      // ---- reset in second ACCESS cycle
      c_req = 1'b1; c_addr = 8'h05; m_rdata = 32'h5555_5555;
      tick();                                   // cycle 1
      c_req = 1'b0;
      tick();                                   // cycle 2
      #2 rst = 1'b0;
      #1;
      check("ar_m_en",   32'(m_en),  32'd0);
      check("ar_busy",   32'(busy),  32'd0);
      check("ar_c_rdat", c_rdata,    32'd0);
      tick();
      check("ar_done",   {30'd0, c_done, d_done}, 32'd0);
      rst = 1'b1;
      c_req = 1'b1; c_addr = 8'h22; m_rdata = 32'hCAFE_1234;
      tick();                                   // cycle 1
      c_req = 1'b0;
      check("ar_c1_m_en", 32'(m_en),   32'd1);
      check("ar_c1_addr", 32'(m_addr), 32'h22);
      tick(); tick();                           // cycle 3
      check("ar_c3_c_done", 32'(c_done), 32'd1);
      check("ar_c3_rdata",  c_rdata,     32'hCAFE_1234);
      tick();

      // ---- requester changes inputs mid-transaction
      c_req = 1'b1; c_addr = 8'h10; m_rdata = 32'h0000_0777;
      tick();                                   // cycle 1
      c_addr = 8'h20; c_req = 1'b0;
      check("chg_c1_addr", 32'(m_addr), 32'h10);
      tick();                                   // cycle 2
      check("chg_c2_addr", 32'(m_addr), 32'h10);
      tick();                                   // cycle 3
      check("chg_c3_done", 32'(c_done), 32'd1);
      check("chg_c3_rdat", c_rdata,     32'h0000_0777);
      tick();                                   // cycle 4
      check("chg_c4_done", 32'(c_done), 32'd0);
      check("chg_c4_busy", 32'(busy),   32'd0);
      tick();
      check("chg_c5_busy", 32'(busy),   32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
